floor_request_scheduler: RTL and testbench

//  Parametrised successor to the 5-button floor decoder. Latches hall/car button presses into a

---
 rtl/floor_request_scheduler.sv | 128 ++++++++++++
 tb/tb_floor_request_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// SCAN-policy elevator request scheduler: latches button presses, clears them on arrival,
// and picks the next destination floor with registered dest/load/dir outputs.
module floor_request_scheduler #(
  parameter int unsigned FLOORS = 5,
  localparam int unsigned FW = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] button,
  input  logic [FW-1:0]     cur_floor,
  input  logic              arrived,
  output logic              load,
  output logic [FW-1:0]     dest,
  output logic              dest_valid,
  output logic [1:0]        dir,
  output logic [FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_e;

  dir_e              state;
  dir_e              state_nx;
  logic [FLOORS-1:0] clr;
  logic [FLOORS-1:0] pending_nx;
  logic              cur_ok;
  logic              here;
  logic              has_above;
  logic              has_below;
  logic [FW-1:0]     above_idx;
  logic [FW-1:0]     below_idx;
  logic              has_target;
  logic [FW-1:0]     target;
  logic              load_nx;

  assign dir    = state;
  assign cur_ok = 32'(cur_floor) < FLOORS;

  // Request register update; an arrival clear beats a same-cycle press of that floor.
  always_comb begin
    clr = '0;
    if (arrived && cur_ok) clr[cur_floor] = 1'b1;
    pending_nx = (pending | button) & ~clr;
  end

  // Nearest pending request strictly above and strictly below the car.
  always_comb begin
    here      = 1'b0;
    has_above = 1'b0;
    has_below = 1'b0;
    above_idx = '0;
    below_idx = '0;
    if (cur_ok) here = pending[cur_floor];
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i < 32'(cur_floor))) begin
        has_below = 1'b1;
        below_idx = FW'(i);
      end
    end
    for (int unsigned j = 0; j < FLOORS; j++) begin
      if (pending[FLOORS-1-j] && ((FLOORS-1-j) > 32'(cur_floor))) begin
        has_above = 1'b1;
        above_idx = FW'(FLOORS-1-j);
      end
    end
  end

  // SCAN next-state and target selection.
  always_comb begin
    state_nx   = state;
    target     = dest;
    has_target = 1'b0;
    if (here) begin
      target     = cur_floor;
      has_target = 1'b1;
    end else begin
      case (state)
        IDLE, UP: begin
          if (has_above) begin
            state_nx   = UP;
            target     = above_idx;
            has_target = 1'b1;
          end else if (has_below) begin
            state_nx   = DOWN;
            target     = below_idx;
            has_target = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        DOWN: begin
          if (has_below) begin
            target     = below_idx;
            has_target = 1'b1;
          end else if (has_above) begin
            state_nx   = UP;
            target     = above_idx;
            has_target = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    load_nx = has_target && (!dest_valid || (target != dest));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      dest       <= '0;
      dest_valid <= 1'b0;
      load       <= 1'b0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      dest_valid <= |pending;
      load       <= load_nx;
      if (has_target) dest <= target;
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: a 5-floor and an 8-floor instance
// driven from one linear sequence of steps with hand-computed expectations.
module tb_floor_request_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic [4:0] button5 = '0;
  logic [2:0] cur5 = '0;
  logic       arrived5 = 1'b0;
  logic       load5;
  logic [2:0] dest5;
  logic       valid5;
  logic [1:0] dir5;
  logic [4:0] pending5;

  logic [7:0] button8 = '0;
  logic [2:0] cur8 = '0;
  logic       arrived8 = 1'b0;
  logic       load8;
  logic [2:0] dest8;
  logic       valid8;
  logic [1:0] dir8;
  logic [7:0] pending8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  floor_request_scheduler #(.FLOORS(5)) dut5 (
    .clk(clk), .reset(reset), .button(button5), .cur_floor(cur5), .arrived(arrived5),
    .load(load5), .dest(dest5), .dest_valid(valid5), .dir(dir5), .pending(pending5)
  );

  floor_request_scheduler #(.FLOORS(8)) dut8 (
    .clk(clk), .reset(reset), .button(button8), .cur_floor(cur8), .arrived(arrived8),
    .load(load8), .dest(dest8), .dest_valid(valid8), .dir(dir8), .pending(pending8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and clear all stimulus.
  task automatic do_reset();
    button5 = '0; arrived5 = 1'b0; button8 = '0; arrived8 = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values, asserted away from any clock edge.
    #1 reset = 1'b1;
    #3;
    chk("rst_load", 32'(load5), 32'd0);
    chk("rst_dest", 32'(dest5), 32'd0);
    chk("rst_valid", 32'(valid5), 32'd0);
    chk("rst_dir", 32'(dir5), 32'd0);
    chk("rst_pending", 32'(pending5), 32'd0);
    #8 reset = 1'b0;
    tick();

    // 1: single press above the car.
    cur5 = 3'd0; button5 = 5'b01000;
    tick();
    button5 = '0;
    chk("t1_pending", 32'(pending5), 32'h08);
    chk("t1_noload_yet", 32'(load5), 32'd0);
    tick();
    chk("t1_load", 32'(load5), 32'd1);
    chk("t1_dest", 32'(dest5), 32'd3);
    chk("t1_dir", 32'(dir5), 32'd1);
    chk("t1_valid", 32'(valid5), 32'd1);
    tick();
    chk("t1_load_once", 32'(load5), 32'd0);

    // 2: preemption in travel direction, then sweep reversal, then idle.
    do_reset();
    cur5 = 3'd2; button5 = 5'b10000;
    tick();
    button5 = '0;
    tick();
    chk("t2_dest4", 32'(dest5), 32'd4);
    button5 = 5'b01010;
    tick();
    button5 = '0;
    tick();
    chk("t2_pre_load", 32'(load5), 32'd1);
    chk("t2_pre_dest", 32'(dest5), 32'd3);
    chk("t2_pre_dir", 32'(dir5), 32'd1);
    cur5 = 3'd3; arrived5 = 1'b1;
    tick();
    arrived5 = 1'b0;
    tick();
    chk("t2_a3_dest", 32'(dest5), 32'd4);
    chk("t2_a3_load", 32'(load5), 32'd1);
    cur5 = 3'd4; arrived5 = 1'b1;
    tick();
    arrived5 = 1'b0;
    tick();
    chk("t2_a4_dir", 32'(dir5), 32'd2);
    chk("t2_a4_dest", 32'(dest5), 32'd1);
    chk("t2_a4_load", 32'(load5), 32'd1);
    cur5 = 3'd1; arrived5 = 1'b1;
    tick();
    arrived5 = 1'b0;
    tick();
    chk("t2_a1_dir", 32'(dir5), 32'd0);
    chk("t2_a1_valid", 32'(valid5), 32'd0);
    chk("t2_a1_load", 32'(load5), 32'd0);
    chk("t2_a1_dest_hold", 32'(dest5), 32'd1);

    // 3: simultaneous requests either side of an idle car; up wins.
    do_reset();
    cur5 = 3'd2; button5 = 5'b10001;
    tick();
    button5 = '0;
    chk("t3_pending", 32'(pending5), 32'h11);
    tick();
    chk("t3_dir", 32'(dir5), 32'd1);
    chk("t3_dest", 32'(dest5), 32'd4);
    chk("t3_load", 32'(load5), 32'd1);

    // 4: arrival clear beats a same-cycle press of the same floor.
    do_reset();
    cur5 = 3'd0; button5 = 5'b01000;
    tick();
    button5 = '0;
    tick();
    tick();
    cur5 = 3'd3; arrived5 = 1'b1; button5 = 5'b01000;
    tick();
    arrived5 = 1'b0; button5 = '0;
    chk("t4_pending_clr", 32'(pending5), 32'd0);
    chk("t4_noload_a", 32'(load5), 32'd0);
    tick();
    chk("t4_noload_b", 32'(load5), 32'd0);
    chk("t4_valid", 32'(valid5), 32'd0);

    // 5: asynchronous reset mid-sweep.
    do_reset();
    cur5 = 3'd2; button5 = 5'b11010;
    tick();
    button5 = '0;
    tick();
    chk("t5_pending", 32'(pending5), 32'h1a);
    chk("t5_dir_up", 32'(dir5), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_pending", 32'(pending5), 32'd0);
    chk("t5_async_dir", 32'(dir5), 32'd0);
    chk("t5_async_dest", 32'(dest5), 32'd0);
    chk("t5_async_valid", 32'(valid5), 32'd0);
    chk("t5_async_load", 32'(load5), 32'd0);
    #1 reset = 1'b0;
    tick(); tick(); tick();
    chk("t5_quiet_load", 32'(load5), 32'd0);
    chk("t5_quiet_valid", 32'(valid5), 32'd0);
    button5 = 5'b00100;
    tick();
    button5 = '0;
    tick();
    chk("t5_here_load", 32'(load5), 32'd1);
    chk("t5_here_dest", 32'(dest5), 32'd2);
    chk("t5_here_dir", 32'(dir5), 32'd0);

    // Arrival reported at a nonexistent floor leaves requests intact.
    cur5 = 3'd6; arrived5 = 1'b1;
    tick();
    arrived5 = 1'b0;
    chk("oob_arrive_pending", 32'(pending5), 32'h04);

    // 6: eight-floor instance, hard ends of the sweep.
    do_reset();
    cur8 = 3'd0; button8 = 8'h80;
    tick();
    button8 = '0;
    tick();
    chk("t6_dest7", 32'(dest8), 32'd7);
    chk("t6_dir_up", 32'(dir8), 32'd1);
    chk("t6_load_up", 32'(load8), 32'd1);
    cur8 = 3'd7; arrived8 = 1'b1;
    tick();
    arrived8 = 1'b0;
    tick();
    chk("t6_idle", 32'(dir8), 32'd0);
    button8 = 8'h01;
    tick();
    button8 = '0;
    tick();
    chk("t6_dir_down", 32'(dir8), 32'd2);
    chk("t6_dest0", 32'(dest8), 32'd0);
    chk("t6_load_down", 32'(load8), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
